// File: rtl/wb_stream_loader.sv
// Byte-stream to Wishbone write master: packs bytes big-endian into 32-bit words
// and writes them to consecutive word addresses, one request outstanding at a time.
module wb_stream_loader #(
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [3:0]        wb_sel_o,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_ack_i,
    input  logic              wb_stall_i,
    output logic              wren_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_adr;
    logic [LEN_W-1:0]  r_rem;
    logic [31:0]       r_word;
    logic [31:0]       r_dat;
    logic [1:0]        r_bcnt;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_cyc;
    logic              r_stb;
    logic              r_ready;
    logic              r_wren;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_ack;
    logic              w_tmo_hit;

    // A zero-wait slave may ack in the same cycle the strobe is accepted.
    assign w_ack     = ((r_state == S_REQ) && !wb_stall_i && wb_ack_i) ||
                       ((r_state == S_WAIT) && wb_ack_i);
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_adr   <= '0;
            r_rem   <= '0;
            r_word  <= '0;
            r_dat   <= '0;
            r_bcnt  <= '0;
            r_tmo   <= '0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_ready <= 1'b0;
            r_wren  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (abort_i && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_bcnt  <= '0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_ready <= 1'b0;
            r_wren  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_adr  <= base_i & ~ADDR_W'(3);
                        r_rem  <= len_i;
                        r_err  <= 1'b0;
                        r_bcnt <= '0;
                        r_busy <= 1'b1;
                        if (len_i == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                            r_ready <= 1'b1;
                            r_wren  <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (in_valid_i) begin
                        r_word <= {r_word[23:0], in_data_i};
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_dat   <= {r_word[23:0], in_data_i};
                            r_ready <= 1'b0;
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_tmo   <= '0;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ, S_WAIT: begin
                    if (w_ack) begin
                        r_adr <= r_adr + ADDR_W'(4);
                        r_rem <= r_rem - LEN_W'(1);
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        if (r_rem == LEN_W'(1)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_wren  <= 1'b0;
                        end else begin
                            r_state <= S_FILL;
                            r_ready <= 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        r_state <= S_ERR;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_wren  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                        if ((r_state == S_REQ) && !wb_stall_i) begin
                            r_stb   <= 1'b0;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o = r_ready;
    assign wb_cyc_o   = r_cyc;
    assign wb_stb_o   = r_stb;
    assign wb_we_o    = r_cyc;
    assign wb_sel_o   = {4{r_cyc}};
    assign wb_adr_o   = r_adr;
    assign wb_dat_o   = r_dat;
    assign wren_o     = r_wren;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;

endmodule

// File: tb/tb_wb_stream_loader.sv
// Directed bench for wb_stream_loader: a 2-cycle-ack Wishbone slave model logs
// every accepted write; the initial block drives the stream and checks outcomes.
module tb_wb_stream_loader;
    logic        clk_i;
    logic        rst_ni;
    logic        start_i;
    logic        abort_i;
    logic [31:0] base_i;
    logic [15:0] len_i;
    logic [7:0]  in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i;
    logic        wb_stall_i;
    logic        wren_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    wb_stream_loader #(.ADDR_W(32), .LEN_W(16), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .base_i(base_i), .len_i(len_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i),
        .wb_stall_i(wb_stall_i), .wren_o(wren_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int tb_cycle = 0;
    always @(posedge clk_i) tb_cycle <= tb_cycle + 1;

    // Slave model: logs accepted strobes, acks during the second cycle after acceptance.
    logic        ack_en = 1'b1;
    int          s_pend = 0;
    logic        s_acc;
    int          n_wr = 0;
    int          n_done = 0;
    logic [31:0] wr_adr [16];
    logic [31:0] wr_dat [16];
    logic [3:0]  wr_sel [16];

    initial wb_ack_i = 1'b0;

    always @(posedge clk_i) begin
        s_acc = wb_cyc_o && wb_stb_o && !wb_stall_i;
        if (s_acc && (n_wr < 16)) begin
            wr_adr[n_wr] = wb_adr_o;
            wr_dat[n_wr] = wb_dat_o;
            wr_sel[n_wr] = wb_sel_o;
        end
        if (s_acc) n_wr = n_wr + 1;
        if (done_o) n_done = n_done + 1;
        #1;
        wb_ack_i = 1'b0;
        if (s_pend > 0) begin
            s_pend = s_pend - 1;
            if (s_pend == 0) wb_ack_i = 1'b1;
        end
        if (s_acc && ack_en) s_pend = 1;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] l);
        base_i  = b;
        len_i   = l;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_data_i  = b;
        in_valid_i = 1'b1;
        while (!in_ready_o && (t < 50)) begin
            tick();
            t++;
        end
        if (t >= 50) chk1("ready_timeout", in_ready_o, 1'b1);
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done_o && (t < 40)) begin
            tick();
            t++;
        end
        chk1(tag, done_o, 1'b1);
    endtask

    int wr0;
    int dn0;
    int t0;

    initial begin
        rst_ni     = 1'b0;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        base_i     = '0;
        len_i      = '0;
        in_data_i  = '0;
        in_valid_i = 1'b0;
        wb_stall_i = 1'b0;
        tick();
        tick();
        chk32("rst_ctrl", 32'({in_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, wren_o,
                               busy_o, done_o, err_o, wb_sel_o}), 32'h0);
        chk32("rst_adr", wb_adr_o, 32'h0);
        chk32("rst_dat", wb_dat_o, 32'h0);
        rst_ni = 1'b1;
        tick();

        // Two words, back-to-back stream, 2-cycle-ack slave.
        wr0 = n_wr;
        dn0 = n_done;
        do_start(32'h0000_0100, 16'd2);
        t0 = tb_cycle;
        chk1("t1_ready", in_ready_o, 1'b1);
        chk1("t1_wren", wren_o, 1'b1);
        chk1("t1_busy", busy_o, 1'b1);
        send_word(32'h1122_3344);
        send_word(32'h5566_7788);
        wait_done("t1_done");
        chk32("t1_latency", 32'(tb_cycle - t0), 32'd14);
        chk1("t1_wren_done", wren_o, 1'b0);
        chk32("t1_nwr", 32'(n_wr - wr0), 32'd2);
        chk32("t1_adr0", wr_adr[wr0], 32'h0000_0100);
        chk32("t1_dat0", wr_dat[wr0], 32'h1122_3344);
        chk32("t1_sel0", 32'(wr_sel[wr0]), 32'hF);
        chk32("t1_adr1", wr_adr[wr0+1], 32'h0000_0104);
        chk32("t1_dat1", wr_dat[wr0+1], 32'h5566_7788);
        tick();
        chk1("t1_done_pulse", done_o, 1'b0);
        chk1("t1_idle_busy", busy_o, 1'b0);
        chk32("t1_ndone", 32'(n_done - dn0), 32'd1);

        // Stall held three cycles in REQ.
        wr0 = n_wr;
        wb_stall_i = 1'b1;
        do_start(32'h0000_0200, 16'd1);
        send_word(32'hAABB_CCDD);
        for (int i = 0; i < 3; i++) begin
            chk1("t2_stb_stall", wb_stb_o, 1'b1);
            chk32("t2_adr_stall", wb_adr_o, 32'h0000_0200);
            chk32("t2_dat_stall", wb_dat_o, 32'hAABB_CCDD);
            tick();
        end
        wb_stall_i = 1'b0;
        chk1("t2_stb_release", wb_stb_o, 1'b1);
        chk32("t2_nwr_before", 32'(n_wr - wr0), 32'd0);
        wait_done("t2_done");
        chk32("t2_nwr", 32'(n_wr - wr0), 32'd1);
        chk32("t2_dat", wr_dat[wr0], 32'hAABB_CCDD);
        tick();

        // Slave never acks: cycle lasts exactly TIMEOUT=8 cycles, then error.
        ack_en = 1'b0;
        dn0 = n_done;
        do_start(32'h0000_0300, 16'd1);
        send_word(32'h0102_0304);
        chk1("t3_cyc_c1", wb_cyc_o, 1'b1);
        repeat (7) tick();
        chk1("t3_cyc_c8", wb_cyc_o, 1'b1);
        chk1("t3_err_c8", err_o, 1'b0);
        tick();
        chk1("t3_cyc_err", wb_cyc_o, 1'b0);
        chk1("t3_stb_err", wb_stb_o, 1'b0);
        chk1("t3_err", err_o, 1'b1);
        chk1("t3_wren_err", wren_o, 1'b0);
        tick();
        chk1("t3_busy_idle", busy_o, 1'b0);
        chk1("t3_err_sticky", err_o, 1'b1);
        chk32("t3_ndone", 32'(n_done - dn0), 32'd0);
        ack_en = 1'b1;
        do_start(32'h0000_0400, 16'd0);
        chk1("t3_err_clr", err_o, 1'b0);
        tick();

        // Abort after two bytes, then reload from base.
        wr0 = n_wr;
        dn0 = n_done;
        do_start(32'h0000_0500, 16'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk1("t4_busy", busy_o, 1'b0);
        chk1("t4_ready", in_ready_o, 1'b0);
        chk1("t4_cyc", wb_cyc_o, 1'b0);
        chk1("t4_wren", wren_o, 1'b0);
        do_start(32'h0000_0500, 16'd1);
        send_word(32'h0A0B_0C0D);
        wait_done("t4_done");
        chk32("t4_nwr", 32'(n_wr - wr0), 32'd1);
        chk32("t4_adr", wr_adr[wr0], 32'h0000_0500);
        chk32("t4_dat", wr_dat[wr0], 32'h0A0B_0C0D);
        tick();
        chk32("t4_ndone", 32'(n_done - dn0), 32'd1);

        // len=0 completes at once; address wraps past the top of the space.
        wr0 = n_wr;
        do_start(32'h0000_0700, 16'd0);
        chk1("t5_done0", done_o, 1'b1);
        chk1("t5_cyc0", wb_cyc_o, 1'b0);
        chk1("t5_ready0", in_ready_o, 1'b0);
        tick();
        chk1("t5_done0_end", done_o, 1'b0);
        chk1("t5_ready0_end", in_ready_o, 1'b0);
        chk32("t5_nwr0", 32'(n_wr - wr0), 32'd0);
        do_start(32'hFFFF_FFFE, 16'd2);
        send_word(32'hDEAD_BEEF);
        send_word(32'h0123_4567);
        wait_done("t5_wrap_done");
        chk32("t5_adr0", wr_adr[wr0], 32'hFFFF_FFFC);
        chk32("t5_adr1", wr_adr[wr0+1], 32'h0000_0000);
        chk32("t5_dat1", wr_dat[wr0+1], 32'h0123_4567);
        tick();

        // Asynchronous reset while waiting for ack.
        wr0 = n_wr;
        do_start(32'h0000_0600, 16'd1);
        send_word(32'h9988_7766);
        tick();
        chk1("t6_wait_cyc", wb_cyc_o, 1'b1);
        chk1("t6_wait_stb", wb_stb_o, 1'b0);
        #2;
        rst_ni     = 1'b0;
        in_data_i  = 8'h99;
        in_valid_i = 1'b1;
        #1;
        chk32("t6_async", 32'({wb_cyc_o, wb_stb_o, wren_o, busy_o}), 32'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk1("t6_ready", in_ready_o, 1'b0);
        chk1("t6_busy", busy_o, 1'b0);
        tick();
        chk1("t6_ready2", in_ready_o, 1'b0);
        in_valid_i = 1'b0;
        chk32("t6_nwr", 32'(n_wr - wr0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
